// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_t;

  function automatic int unsigned max_ticks(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Row 0 has the highest priority when several rows are pulled low.
  function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    casez (rows)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pins and decoded key outputs; slave is the scanner side.
interface keypad_if import keypad_pkg::*; ();

  logic [NUM_ROWS-1:0]   keypad_row_i;
  logic [NUM_COLS-1:0]   keypad_column_o;
  logic [KEY_CODE_W-1:0] key_code_o;
  logic                  key_valid_o;
  logic                  key_held_o;

  modport slave (
    input  keypad_row_i,
    output keypad_column_o, key_code_o, key_valid_o, key_held_o
  );

  modport master (
    output keypad_row_i,
    input  keypad_column_o, key_code_o, key_valid_o, key_held_o
  );

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module keypad_row_sync import keypad_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [NUM_ROWS-1:0] row_sync_o
);

  logic [NUM_ROWS-1:0] meta_q;
  logic [NUM_ROWS-1:0] sync_q;

  // Reset to all ones so no key appears pressed while leaving reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_sync_o = sync_q;

endmodule

// File: rtl/keypad_scan_controller.sv
// Column scanner with press/release debounce for a 4x4 active-low keypad.
module keypad_scan_controller import keypad_pkg::*; #(
  parameter int unsigned SCAN_TICKS     = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 100000
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.slave  kp
);

  localparam int unsigned        CNT_W     = $clog2(max_ticks(SCAN_TICKS, DEBOUNCE_TICKS));
  localparam logic [CNT_W-1:0]   SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_COLS-1:0] COL_SEL  = 4'b0001;

  scan_state_t           state_q, state_d;
  logic [1:0]            col_q, col_d;
  logic [1:0]            row_q, row_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_COLS-1:0]   column_q, column_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q, key_held_d;
  logic [NUM_ROWS-1:0]   srow;
  logic                  row_lvl;

  keypad_row_sync u_row_sync (
    .clk        (clk),
    .rst        (rst),
    .row_i      (kp.keypad_row_i),
    .row_sync_o (srow)
  );

  assign row_lvl = srow[row_q];

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = CNT_ZERO;
          if (srow == 4'b1111) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = first_low_row(srow);
            state_d = PRESS_DB;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESS_DB: begin
        if (row_lvl) begin
          col_d   = col_q + 2'd1;
          cnt_d   = CNT_ZERO;
          state_d = SCAN;
        end else if (cnt_q == DB_LAST) begin
          cnt_d       = CNT_ZERO;
          key_code_d  = {row_q, col_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (row_lvl) begin
          cnt_d   = CNT_ZERO;
          state_d = RELEASE_DB;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      RELEASE_DB: begin
        if (!row_lvl) begin
          cnt_d   = CNT_ZERO;
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          cnt_d      = CNT_ZERO;
          key_held_d = 1'b0;
          col_d      = col_q + 2'd1;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = SCAN;
      end
    endcase
    column_d = ~(COL_SEL << col_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= CNT_ZERO;
      column_q    <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      column_q    <= column_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.keypad_column_o = column_q;
  assign kp.key_code_o      = key_code_q;
  assign kp.key_valid_o     = key_valid_q;
  assign kp.key_held_o      = key_held_q;

endmodule

// File: doc/keypad_scan_controller.md
KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

Interface
REQ-001 SCAN_TICKS, 1000, clk cycles each column is driven before rows are sampled (>=2).
REQ-002 DEBOUNCE_TICKS, 100000, consecutive stable clk cycles required to accept a press or a release (>=2).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 keypad_row  input  4  raw keypad rows, active-low, asynchronous to clk.
REQ-006 keypad_column  output  4  column drive, active-low; exactly one bit low at all times.
REQ-007 key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when key_code is updated by a new accepted press.
REQ-009 key_held  output  1  high while an accepted key is not yet debounced as released.

Function
REQ-010 keypad_row SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (srow).
REQ-011 FSM states SHALL be SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-012 SCAN: drive column col_idx low; tick counter counts 0..SCAN_TICKS-1; at count SCAN_TICKS-1, sample srow.
REQ-013 SCAN sample, srow == 4'b1111: col_idx increments modulo 4 (3 wraps to 0), counter clears, stay SCAN.
REQ-014 SCAN sample, any srow bit low: latch row_idx = lowest-index low bit (row 0 highest priority), counter clears, go PRESS_DB; col_idx frozen.
REQ-015 PRESS_DB: counter increments each cycle srow[row_idx]==0; if srow[row_idx]==1 on any cycle, advance col_idx modulo 4, clear counter, return SCAN with no key_valid.
REQ-016 PRESS_DB: on the cycle counter reaches DEBOUNCE_TICKS-1 with srow[row_idx]==0, next cycle key_code <= {row_idx, col_idx}, key_valid=1 for exactly that cycle, key_held=1, state HELD.
REQ-017 HELD: col_idx and row_idx frozen; other rows/keys ignored; srow[row_idx]==1 moves to RELEASE_DB with counter cleared.
REQ-018 RELEASE_DB: counter increments each cycle srow[row_idx]==1; srow[row_idx]==0 returns HELD (bounce) with counter cleared and no new key_valid.
REQ-019 RELEASE_DB: at counter DEBOUNCE_TICKS-1 with srow[row_idx]==1, next cycle key_held=0, col_idx advances modulo 4, state SCAN.
REQ-020 key_code SHALL hold its value until the next accepted press; key_valid never asserts twice per physical press.
REQ-021 Counters SHALL be sized $clog2(max(SCAN_TICKS, DEBOUNCE_TICKS)) bits and never overflow (cleared on every state change).
REQ-022 keypad_column SHALL equal ~(4'b0001 << col_idx), registered, changing only on the cycle col_idx updates.

Reset
REQ-023 Reset SHALL force state SCAN, col_idx=0, row_idx=0, counters=0, synchronizer flops=4'b1111.
REQ-024 During and after reset: keypad_column=4'b1110, key_code=4'h0, key_valid=0, key_held=0.
REQ-025 Reset asserted mid-debounce or in HELD SHALL abort with no key_valid pulse; scanning restarts at column 0 on the first clk after deassertion.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum (scan_state_t) and the constants KEY_CODE_W=4, NUM_ROWS=4, NUM_COLS=4.
REQ-027 One sub-module keypad_row_sync (4-bit 2-flop synchronizer, async reset to all ones) SHALL be instantiated; FSM, counters and column drive stay in keypad_scan_controller.
REQ-028 Implementation SHALL be fully synchronous to clk apart from the async reset; no derived clocks or edge-sensitive use of data signals.

Verification (SCAN_TICKS=4, DEBOUNCE_TICKS=8)
REQ-029 Idle rows 4'b1111 for 40 cycles -> keypad_column cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never high.
REQ-030 Hold row 2 low while column 1 driven, for 30 cycles -> one key_valid pulse, key_code=4'b1001, key_held=1, keypad_column stays 4'b1101.
REQ-031 Row 0 low for 3 cycles during PRESS_DB then high -> no key_valid; scanning resumes at next column.
REQ-032 In HELD, release with a 3-cycle bounce, then stay high 12 cycles -> no second key_valid; key_held falls once; column advances to 1011.
REQ-033 Rows 1 and 3 low together on column 2 -> key_code=4'b0110 (row 1 wins).
REQ-034 Reset asserted in RELEASE_DB -> key_held=0, keypad_column=4'b1110 immediately (asynchronous), no key_valid after deassertion until a new debounced press.
